// File: rtl/frame_aligner_gen2_pkg.sv
// Shared types for the frame aligner: FSM state enum and the sync_state
// output encoding.
package frame_aligner_pkg;

   typedef enum logic [1:0] {
      FA_HUNT   = 2'd0,
      FA_VERIFY = 2'd1,
      FA_LOCKED = 2'd2
   } fa_state_e;

   localparam logic [1:0] SYNC_HUNT   = 2'd0;
   localparam logic [1:0] SYNC_VERIFY = 2'd1;
   localparam logic [1:0] SYNC_LOCKED = 2'd2;

   // Code 3 is never produced, but it must read back as HUNT.
   function automatic logic [1:0] fa_encode(input fa_state_e s);
      case (s)
         FA_VERIFY: return SYNC_VERIFY;
         FA_LOCKED: return SYNC_LOCKED;
         default:   return SYNC_HUNT;
      endcase
   endfunction

endpackage

// File: rtl/frame_aligner_gen2_hdr_matcher.sv
// Sliding header window over the last HDR_BYTES accepted words. It flags
// a header when the window, including the word accepted this cycle, equals
// the pattern.
module fa_hdr_matcher
   import frame_aligner_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int HDR_BYTES = 2,
   parameter logic [HDR_BYTES*DATA_W-1:0] HDR_PATTERN = 16'hAFAA
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              hdr_match
);

   localparam int HW = HDR_BYTES * DATA_W;
   localparam int FW = $clog2(HDR_BYTES + 1);
   localparam logic [FW-1:0] FULL = FW'(HDR_BYTES);

   logic [HW-1:0] win_q, win_d, win_shift;
   logic [FW-1:0] fill_q, fill_d;

   // Oldest word sits in the low bits, so word 0 of the pattern lines up.
   generate
      if (HDR_BYTES == 1) begin : g_one
         assign win_shift = in_data;
      end else begin : g_many
         assign win_shift = {in_data, win_q[HW-1:DATA_W]};
      end
   endgenerate

   always_comb begin
      win_d  = win_q;
      fill_d = fill_q;
      if (in_valid) begin
         win_d = win_shift;
         if (fill_q != FULL) fill_d = fill_q + 1'b1;
      end
   end

   // Matching on the next-window value lets the FSM act on the same edge
   // that accepts the header's last word.
   assign hdr_match = in_valid && (fill_d == FULL) && (win_d == HDR_PATTERN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/frame_aligner_gen2.sv
// Frame aligner: finds a periodic header in the received word stream and
// tracks lock with HUNT/VERIFY/LOCKED and acquire/loss hysteresis.
module frame_aligner_gen2
   import frame_aligner_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int HDR_BYTES = 2,
   parameter logic [HDR_BYTES*DATA_W-1:0] HDR_PATTERN = 16'hAFAA,
   parameter int FRAME_LEN = 12,
   parameter int SYNC_IN   = 3,
   parameter int SYNC_OUT  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            rx_data,
   input  logic                         rx_valid,
   output logic [$clog2(FRAME_LEN)-1:0] fr_byte_position,
   output logic                         frame_detect,
   output logic                         frame_start,
   output logic [1:0]                   sync_state
);

   localparam int PW       = $clog2(FRAME_LEN);
   localparam int SYNC_MAX = (SYNC_IN > SYNC_OUT) ? SYNC_IN : SYNC_OUT;
   localparam int CW       = $clog2(SYNC_MAX + 1);

   localparam logic [PW-1:0] HDR_POS    = PW'(HDR_BYTES - 1);
   localparam logic [PW-1:0] LAST_POS   = PW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] SYNC_IN_C  = CW'(SYNC_IN);
   localparam logic [CW-1:0] SYNC_OUT_C = CW'(SYNC_OUT);
   localparam fa_state_e     ACQ_STATE  = (SYNC_IN == 1) ? FA_LOCKED : FA_VERIFY;

   fa_state_e     state_q, state_d;
   logic [PW-1:0] pos_q, pos_d, pos_inc;
   logic [CW-1:0] good_q, good_d, good_inc;
   logic [CW-1:0] bad_q, bad_d, bad_inc;
   logic          start_q, start_d;
   logic          hdr_match;

   fa_hdr_matcher #(
      .DATA_W      (DATA_W),
      .HDR_BYTES   (HDR_BYTES),
      .HDR_PATTERN (HDR_PATTERN)
   ) u_matcher (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rx_valid),
      .in_data   (rx_data),
      .hdr_match (hdr_match)
   );

   assign pos_inc  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
   assign good_inc = good_q + 1'b1;
   assign bad_inc  = bad_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      good_d  = good_q;
      bad_d   = bad_q;
      start_d = 1'b0;
      if (rx_valid) begin
         case (state_q)
            FA_VERIFY: begin
               pos_d = pos_inc;
               if (pos_inc == HDR_POS) begin
                  if (hdr_match) begin
                     good_d = good_inc;
                     if (good_inc == SYNC_IN_C) begin
                        state_d = FA_LOCKED;
                        bad_d   = '0;
                     end
                  end else begin
                     state_d = FA_HUNT;
                     pos_d   = '0;
                     good_d  = '0;
                  end
               end
            end
            FA_LOCKED: begin
               pos_d = pos_inc;
               if (pos_inc == HDR_POS) begin
                  if (hdr_match) begin
                     bad_d   = '0;
                     start_d = 1'b1;
                  end else if (bad_inc == SYNC_OUT_C) begin
                     state_d = FA_HUNT;
                     pos_d   = '0;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_inc;
                  end
               end
            end
            default: begin
               // HUNT, and the unused encoding treated the same way.
               state_d = FA_HUNT;
               pos_d   = '0;
               if (hdr_match) begin
                  state_d = ACQ_STATE;
                  pos_d   = HDR_POS;
                  good_d  = CW'(1);
                  bad_d   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FA_HUNT;
         pos_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         start_q <= start_d;
      end
   end

   assign fr_byte_position = pos_q;
   assign frame_detect     = (state_q == FA_LOCKED);
   assign frame_start      = start_q;
   assign sync_state       = fa_encode(state_q);

endmodule

// File: doc/frame_aligner_gen2.md
# frame_aligner_gen2

Parametrised successor to the fixed-format frame aligner, with configurable data width, header pattern, frame length and sync hysteresis. It sits directly after the receive deserialiser and searches the incoming word stream for a periodic header. It reports lock through a HUNT/VERIFY/LOCKED state machine with separate acquire and loss thresholds. Adds an input-valid qualifier and a per-frame start strobe.

## Interface
- DATA_W, 8: width of one received word (byte).
- HDR_BYTES, 2: number of words in the frame header, ≥1.
- HDR_PATTERN, 16'hAFAA: header, HDR_BYTES*DATA_W bits; word 0 (first received) is bits [DATA_W-1:0].
- FRAME_LEN, 12: words per frame including header, > HDR_BYTES.
- SYNC_IN, 3: consecutive correctly spaced headers needed to lock, ≥1.
- SYNC_OUT, 4: consecutive bad headers while LOCKED before lock is dropped, ≥1.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rx_data  in  DATA_W  received word.
- rx_valid  in  1  rx_data valid this cycle; only valid words are accepted.
- fr_byte_position  out  $clog2(FRAME_LEN)  index of the most recently accepted word within the frame.
- frame_detect  out  1  1 while in LOCKED.
- frame_start  out  1  one-cycle pulse on each good header while LOCKED.
- sync_state  out  2  0=HUNT, 1=VERIFY, 2=LOCKED.

## Operation
- Accepted word = rx_data with rx_valid=1. With rx_valid=0, no state, counter or output changes (frame_start 0).
- Header window: shift register of the last HDR_BYTES accepted words plus a saturating fill counter. The window is valid once HDR_BYTES words have been accepted since reset.
- HUNT: compare the window after every accepted word. On a match: go to VERIFY, set fr_byte_position=HDR_BYTES-1, set good_cnt=1. If SYNC_IN=1, go straight to LOCKED. fr_byte_position holds 0 in HUNT.
- Outside HUNT, fr_byte_position increments per accepted word and wraps FRAME_LEN-1→0. A header check occurs when the new position equals HDR_BYTES-1.
- VERIFY: on a match, good_cnt++; when it reaches SYNC_IN, go to LOCKED. On a mismatch, go to HUNT with position 0 and good_cnt 0. The failing window is not re-checked.
- LOCKED: on a match, clear bad_cnt and pulse frame_start. On a mismatch, bad_cnt++; when it reaches SYNC_OUT, go to HUNT and clear all counters. Otherwise stay LOCKED; position keeps free-running.
- No other transitions. Unused sync_state code 3 is unreachable and decodes as HUNT.

## Timing
- All outputs registered. A state change caused by the word accepted at edge N is visible after edge N.
- frame_detect rises in the cycle after the last word of the SYNC_IN-th header is accepted. It falls in the cycle after the last word of the SYNC_OUT-th consecutive bad header.
- frame_start is coincident with the position update to HDR_BYTES-1 on a good LOCKED header.
- Reset values: sync_state=HUNT, fr_byte_position=0, frame_detect=0, frame_start=0, good_cnt=bad_cnt=0, window and fill counter 0.
- Reset mid-operation clears everything asynchronously. Re-acquisition requires a full HDR_BYTES refill.

## Structure
- Package frame_aligner_pkg: fa_state_e enum {FA_HUNT, FA_VERIFY, FA_LOCKED} and the sync_state encodings.
- Sub-module fa_hdr_matcher: window shift register, fill counter and comparator. Its output is the registered-input combinational `hdr_match`.
- Top: FSM, position counter, good_cnt/bad_cnt sized $clog2(max(SYNC_IN,SYNC_OUT)+1).

## Test plan
- Defaults: reset, then 3 frames "AA AF" + 10 payload words, rx_valid=1 → position steps 1..11,0,1. frame_detect=1 and sync_state=2 the cycle after the 3rd header's AF. No frame_start before lock.
- Locked, then 3 frames with corrupted header (AA 00), then a good one → frame_detect stays 1 with no frame_start on bad frames. Next, 4 consecutive bad headers → frame_detect=0 after the 4th; sync_state=0.
- HUNT with "AA AF" inside payload at offset 5 → VERIFY, mismatch 12 words later → HUNT. Locks on true alignment after 3 true headers.
- Repeat scenario 1 with rx_valid random 50% → identical accepted-word trace; position and outputs frozen on invalid cycles.
- reset=0 asynchronously mid-LOCKED (between clock edges) → all outputs 0 immediately. After release, lock needs 3 fresh headers.
- DATA_W=16, HDR_BYTES=1, HDR_PATTERN=16'h47B5, FRAME_LEN=8, SYNC_IN=1, SYNC_OUT=2 → lock on the first 47B5. Position runs 0..7 and wraps; lock drops after 2 missing headers.
